i2c_master: RTL



---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_tick_gen.sv | 45 ++++
 rtl/i2c_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the byte-oriented I2C master.
//   state_t   - master FSM states
//   phase_t   - quarter-phase of an SCL bit period (q0..q3)
//   RW_*      - transfer direction encoding
//   ACK/NACK  - SDA level in the acknowledge slot
//   scl_high  - SCL level for a normal data/ack bit in a given quarter
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSendByte,
        StGetAck,
        StRstart,
        StRecvByte,
        StSendNack,
        StStop
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // q0/q1: SCL low (SDA changes at q0); q2/q3: SCL high (sample at q2->q3)
    typedef enum logic [1:0] {
        PhQ0 = 2'd0,
        PhQ1 = 2'd1,
        PhQ2 = 2'd2,
        PhQ3 = 2'd3
    } phase_t;

    function automatic logic scl_high(input phase_t ph);
        return (ph == PhQ2) || (ph == PhQ3);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-bit timebase for the I2C master.
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   en     in   run enable (master busy); counter and phase clear while low
//   qtick  out  one-cycle pulse on the last clock of each quarter
//   phase  out  current quarter of the bit period
// While idle the phase rests at q2 so that the 2-quarter START occupies
// q2/q3 and the first data bit begins on a clean q0.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned QDIV = 250
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output logic   qtick,
    output phase_t phase
);

    localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q;
    phase_t        phase_q;

    assign qtick = en && (cnt_q == CNT_MAX);
    assign phase = phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= PhQ2;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= PhQ2;
        end else if (qtick) begin
            cnt_q   <= '0;
            phase_q <= phase_t'(phase_q + 2'd1);
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-register write/read I2C master (no clock stretching).
//   clk         in     system clock
//   reset       in     asynchronous, active-high reset
//   start       in     one-cycle request, honoured only when idle
//   rw          in     0 = write, 1 = read (latched with start)
//   slave_addr  in     7-bit target address (latched with start)
//   reg_addr    in     register index byte (latched with start)
//   wdata       in     write data byte (latched with start)
//   rdata       out    last byte read; updated only by a successful read
//   busy        out    high from the cycle after start through end of STOP
//   done        out    one-cycle pulse as busy falls
//   ack_err     out    a slave ACK was missing; holds until next start
//   SCL         out    push-pull clock
//   SDA         inout  open-drain data (drives 0 or Z)
// QDIV = CLK_FREQ / (4 * SCL_FREQ) must be at least 2.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCL_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] slave_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int unsigned QDIV = CLK_FREQ / (4 * SCL_FREQ);

    state_t     state_q, state_d;
    logic       qtick;
    phase_t     phase;
    logic       end_q2, end_q3;

    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] byte_cnt_q;   // 0: addr-W, 1: reg, 2: wdata or addr-R
    logic       samp_q;       // SDA captured at the SCL-high midpoint
    logic [7:0] rdata_q;
    logic       ack_err_q;
    logic       done_q;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign SCL     = scl_q;
    assign SDA     = sda_oe_q ? 1'b0 : 1'bz;

    assign end_q2 = qtick && (phase == PhQ2);
    assign end_q3 = qtick && (phase == PhQ3);

    i2c_tick_gen #(
        .QDIV (QDIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .qtick (qtick),
        .phase (phase)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every state advances on the last quarter of its period
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StStart;
            StStart:    if (end_q3) state_d = StSendByte;
            StSendByte: if (end_q3 && (bit_cnt_q == 3'd0)) state_d = StGetAck;
            StGetAck: begin
                if (end_q3) begin
                    if (samp_q == NACK) begin
                        state_d = StStop;
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    state_d = StSendByte;
                            2'd1:    state_d = (rw_q == RW_READ) ? StRstart : StSendByte;
                            default: state_d = (rw_q == RW_READ) ? StRecvByte : StStop;
                        endcase
                    end
                end
            end
            StRstart:   if (end_q3) state_d = StSendByte;
            StRecvByte: if (end_q3 && (bit_cnt_q == 3'd0)) state_d = StSendNack;
            StSendNack: if (end_q3) state_d = StStop;
            StStop:     if (end_q3) state_d = StIdle;
        endcase
    end

    // Bus levels per state and quarter; registered below so the pins never glitch
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        unique case (state_q)
            StIdle: ;
            StStart: sda_oe_d = 1'b1;
            StSendByte: begin
                scl_d    = scl_high(phase);
                sda_oe_d = ~shift_q[7];
            end
            StGetAck, StRecvByte, StSendNack: scl_d = scl_high(phase);
            StRstart: begin
                // release SDA low, raise SCL, pull SDA while high, drop SCL
                scl_d    = (phase == PhQ1) || (phase == PhQ2);
                sda_oe_d = scl_high(phase);
            end
            StStop: begin
                scl_d    = scl_high(phase);
                sda_oe_d = (phase != PhQ3);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    // Datapath: latched request, shift register, counters, results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q       <= RW_WRITE;
            addr_q     <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            samp_q     <= 1'b1;
            rdata_q    <= '0;
            ack_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == StStop) && end_q3;

            if ((state_q == StIdle) && start) begin
                rw_q       <= rw;
                addr_q     <= slave_addr;
                reg_q      <= reg_addr;
                wdata_q    <= wdata;
                shift_q    <= {slave_addr, RW_WRITE};
                bit_cnt_q  <= 3'd7;
                byte_cnt_q <= 2'd0;
                ack_err_q  <= 1'b0;
            end

            if (end_q2) begin
                samp_q <= SDA;
            end

            if (end_q3) begin
                case (state_q)
                    StSendByte, StRecvByte: begin
                        if (bit_cnt_q != 3'd0) begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            shift_q   <= {shift_q[6:0], samp_q};
                        end else if (state_q == StRecvByte) begin
                            rdata_q <= {shift_q[6:0], samp_q};
                        end
                    end
                    StGetAck: begin
                        if (samp_q == NACK) begin
                            ack_err_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            bit_cnt_q  <= 3'd7;
                            if (byte_cnt_q == 2'd0) begin
                                shift_q <= reg_q;
                            end else if (byte_cnt_q == 2'd1) begin
                                shift_q <= wdata_q;
                            end
                        end
                    end
                    StRstart: begin
                        shift_q   <= {addr_q, RW_READ};
                        bit_cnt_q <= 3'd7;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
